// File: rtl/prog_loader.sv
// UART program loader: receives an 8N1 framed image (0xA5, N, 4*N data bytes, XOR checksum),
// writes little-endian words to the icache write port and releases the core once the image checks out.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned N_W       = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;
  localparam logic [7:0]  HEADER    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_DATA, ST_CHECK, ST_RUN, ST_ERROR} state_e;

  // ---------------- UART receiver ----------------
  logic [1:0]       rx_sync_q;
  logic             rx_s, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx_i};
      rx_prev_q    <= rx_s;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Bit-timing FSM: start bit checked at half a bit, then one sample per bit period.
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d    = '0;
          byte_valid_d = rx_s;
          frame_err_d  = !rx_s;
          rx_state_d   = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Loader ----------------
  state_e            state_q, state_d;
  logic [N_W-1:0]    n_words_q, n_words_d;
  logic [N_W-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic              core_rst_nd, busy_d, done_d, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      n_words_q   <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      core_rst_no <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_words_q   <= n_words_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      wr_en_o     <= wr_en_d;
      wr_addr_o   <= wr_addr_d;
      wr_data_o   <= wr_data_d;
      core_rst_no <= core_rst_nd;
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_words_d  = n_words_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (byte_valid_q && shift_q == HEADER) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (frame_err_q) begin
          state_d = ST_ERROR;
        end else if (byte_valid_q) begin
          if (shift_q == 8'd0 || 32'(shift_q) > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            n_words_d  = N_W'(shift_q);
            word_cnt_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            wr_addr_d  = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (frame_err_q) begin
          state_d = ST_ERROR;
        end else if (byte_valid_q) begin
          csum_d     = csum_q ^ shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = ADDR_W'(word_cnt_q);
              wr_data_d  = {shift_q, word_q};
              word_cnt_d = word_cnt_q + N_W'(1);
              if (word_cnt_q == n_words_q - N_W'(1)) state_d = ST_CHECK;
            end
          endcase
        end
      end
      ST_CHECK: begin
        if (frame_err_q) state_d = ST_ERROR;
        else if (byte_valid_q) state_d = (shift_q == csum_q) ? ST_RUN : ST_ERROR;
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    core_rst_nd = (state_d == ST_RUN);
    busy_d      = (state_d == ST_COUNT) || (state_d == ST_DATA) || (state_d == ST_CHECK);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERROR);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte-level reference model of the frame protocol, directed plan cases
// plus randomized frames, with a per-cycle compare process for writes and status.
module tb_prog_loader;

  localparam int unsigned CPB  = 4;
  localparam int unsigned AW   = 6;
  localparam int          NMAX = 64;

  localparam int M_IDLE = 0, M_COUNT = 1, M_DATA = 2, M_CHECK = 3, M_RUN = 4, M_ERROR = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_i = 1'b1;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0]   wr_data_o;
  logic          core_rst_no, busy_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .core_rst_no (core_rst_no),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  int total = 0;
  int passed = 0;
  bit settled = 1'b0;

  // Reference model state
  int            m_mode, m_n, m_bidx, m_wcnt;
  logic [7:0]    m_csum;
  logic [31:0]   m_word;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   wbuf[NMAX];
  logic [7:0]    fr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ferr);
    if (ferr) begin
      if (m_mode == M_COUNT || m_mode == M_DATA || m_mode == M_CHECK) m_mode = M_ERROR;
      return;
    end
    case (m_mode)
      M_IDLE, M_ERROR: if (b == 8'hA5) m_mode = M_COUNT;
      M_COUNT: begin
        if (b == 0 || int'(b) > NMAX) m_mode = M_ERROR;
        else begin
          m_n = int'(b); m_wcnt = 0; m_bidx = 0; m_csum = 0; m_word = 0; m_mode = M_DATA;
        end
      end
      M_DATA: begin
        m_csum = m_csum ^ b;
        m_word[8*m_bidx +: 8] = b;
        m_bidx++;
        if (m_bidx == 4) begin
          exp_addr.push_back(AW'(m_wcnt));
          exp_data.push_back(m_word);
          m_wcnt++; m_bidx = 0; m_word = 0;
          if (m_wcnt == m_n) m_mode = M_CHECK;
        end
      end
      M_CHECK: m_mode = (b == m_csum) ? M_RUN : M_ERROR;
      default: ;
    endcase
  endtask

  function automatic logic [3:0] exp_status();
    logic [3:0] s;
    s[3] = (m_mode == M_RUN);
    s[2] = (m_mode == M_COUNT || m_mode == M_DATA || m_mode == M_CHECK);
    s[1] = (m_mode == M_RUN);
    s[0] = (m_mode == M_ERROR);
    return s;
  endfunction

  // Per-cycle comparison of write port and (when the line is quiet) status outputs
  always @(posedge clk_i) begin
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    #1;
    if (wr_en_o === 1'b1) begin
      if (exp_addr.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0d data %h, want no write", wr_addr_o, wr_data_o);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        chk("write_addr_data", {26'd0, wr_addr_o, wr_data_o}, {26'd0, ea, ed});
      end
    end
    if (settled) chk("status", 64'({core_rst_no, busy_o, done_o, err_o}), 64'(exp_status()));
  end

  task automatic make_frame(input int n, output logic [7:0] q[$]);
    logic [7:0] cs;
    q.delete();
    cs = 8'd0;
    q.push_back(8'hA5);
    q.push_back(8'(n));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        q.push_back(wbuf[i][8*j +: 8]);
        cs = cs ^ wbuf[i][8*j +: 8];
      end
    q.push_back(cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = !bad_stop;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
    repeat ($urandom_range(2, 12)) @(negedge clk_i);
  endtask

  task automatic model_frame(input logic [7:0] q[$], input int bad_idx);
    foreach (q[i]) model_byte(q[i], i == bad_idx);
  endtask

  task automatic drive_frame(input logic [7:0] q[$], input int bad_idx);
    settled = 1'b0;
    foreach (q[i]) send_byte(q[i], i == bad_idx);
    repeat (12) @(negedge clk_i);
    settled = 1'b1;
    @(negedge clk_i);
    chk("writes_drained", 64'(exp_addr.size()), 64'd0);
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int bad_idx);
    model_frame(q, bad_idx);
    drive_frame(q, bad_idx);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    rx_i = 1'b1;
    model_reset();
    settled = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", 64'({wr_en_o, wr_addr_o, wr_data_o, core_rst_no, busy_o, done_o, err_o}), 64'd0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle line: nothing happens
    repeat (1000) @(negedge clk_i);
    chk("idle_core_rst", 64'(core_rst_no), 64'd0);

    // Plan frame; pin the model against hand-computed values first
    wbuf[0] = 32'h0000_0013;
    wbuf[1] = 32'h0010_00B3;
    make_frame(2, fr);
    chk("pin_frame_csum", 64'(fr[10]), 64'hB0);
    model_frame(fr, -1);
    chk("pin_model_n_writes", 64'(exp_data.size()), 64'd2);
    chk("pin_model_word0", 64'(exp_data[0]), 64'h13);
    chk("pin_model_word1", {32'd0, exp_data[1]}, 64'h0010_00B3);
    chk("pin_model_addr1", 64'(exp_addr[1]), 64'd1);
    chk("pin_model_run", 64'(exp_status()), 64'b1010);
    drive_frame(fr, -1);
    chk("plan_done", 64'({core_rst_no, done_o}), 64'b11);

    // Bad checksum, then correct frame from ERROR
    do_reset();
    fr[10] = 8'hB1;
    model_frame(fr, -1);
    chk("pin_model_err", 64'(exp_status()), 64'b0001);
    drive_frame(fr, -1);
    chk("badcsum_err", 64'({core_rst_no, err_o}), 64'b01);
    fr[10] = 8'hB0;
    send_frame(fr, -1);
    chk("recover_done", 64'(done_o), 64'd1);

    // Illegal counts
    do_reset();
    fr = '{8'hA5, 8'h00};
    send_frame(fr, -1);
    chk("count0_err", 64'(err_o), 64'd1);
    fr = '{8'hA5, 8'h41};
    send_frame(fr, -1);
    chk("count65_err", 64'(err_o), 64'd1);

    // Framing error on the second data byte
    do_reset();
    make_frame(2, fr);
    send_frame(fr, 3);
    chk("stopbit_err", 64'(err_o), 64'd1);

    // Single-cycle glitch on idle line
    do_reset();
    @(negedge clk_i) rx_i = 1'b0;
    @(negedge clk_i) rx_i = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("glitch_idle", 64'({busy_o, done_o, err_o}), 64'd0);

    // Reset mid-word after 6 data bytes, then a full frame containing 0xA5 data bytes
    do_reset();
    make_frame(2, fr);
    fr = fr[0:7];
    send_frame(fr, -1);
    chk("midword_busy", 64'(busy_o), 64'd1);
    do_reset();
    wbuf[0] = 32'hA5A5_A5A5;
    wbuf[1] = 32'h0000_00A5;
    make_frame(2, fr);
    send_frame(fr, -1);
    chk("after_reset_done", 64'(done_o), 64'd1);

    // Traffic in RUN is ignored
    send_frame(fr, -1);
    chk("run_sticky", 64'(done_o), 64'd1);

    // Randomized frames with random corruption
    for (int k = 0; k < 6; k++) begin
      int n, kind, bad;
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      make_frame(n, fr);
      kind = $urandom_range(0, 3);
      bad = -1;
      if (kind == 1) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 2) bad = $urandom_range(1, fr.size() - 1);
      if (kind == 3) begin
        fr.push_front(8'($urandom));
        fr.push_front(8'($urandom));
      end
      send_frame(fr, bad);
    end

    // Full 64-word image
    do_reset();
    for (int i = 0; i < NMAX; i++) wbuf[i] = $urandom;
    make_frame(NMAX, fr);
    send_frame(fr, -1);
    chk("full_image_done", 64'({core_rst_no, done_o, err_o}), 64'b110);

    settled = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
